// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter, the receiver and the
// baud counter: FSM state encoding, idle line level and timing helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Clock cycles per line symbol (integer division, truncating).
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// N-cycle symbol timer shared by the UART transmitter and receiver.
// Counts 0..N-1 and wraps; tick marks the last cycle of a symbol.
// clear holds the count at 0 (used while the line is idle).
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int N = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = counter_width(N);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] count;

  // Symbol cycle counter: held at zero by clear, wraps on the last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !clear && (count == LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// UART serializer at the dequeue end of a byte stream.
// Accepts a byte on a valid/ready port and sends it as start, WIDTH data
// bits LSB first, optional even parity, stop.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
//
// Handshake: a byte transfers on any rising edge where in_valid and
// in_ready are both high. in_ready depends only on FSM state (high in IDLE
// once out of reset) and never on in_valid; in_data is sampled only on that
// transfer edge and ignored at all other times.
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             serial_out,
  output logic             busy
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int IDX_W = counter_width(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  tx_state_t        state;
  tx_state_t        next_state;
  logic [WIDTH-1:0] shift_q;
  logic [IDX_W-1:0] bit_idx_q;
  logic             armed_q;
  logic             fire;
  logic             tick;
  logic             baud_clear;
  logic             load;
  logic             shift_en;
  logic             idx_clr;
  logic             idx_inc;
  logic             line;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  assign in_ready   = armed_q && (state == IDLE);
  assign fire       = in_valid && in_ready;
  assign busy       = (state != IDLE);
  // The line is decoded straight from the state register so an async reset
  // returns it to idle-high immediately, without waiting for a clock.
  assign serial_out = line;

  uart_baud_counter #(
    .N (SYMBOL_EDGE_TIME)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clear),
    .tick  (tick)
  );

  // State register; reset discards any frame in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state, line level and datapath controls.
  always_comb begin
    next_state = state;
    baud_clear = 1'b0;
    load       = 1'b0;
    shift_en   = 1'b0;
    idx_clr    = 1'b0;
    idx_inc    = 1'b0;
    line       = UART_IDLE_LEVEL;
    case (state)
      IDLE: begin
        baud_clear = 1'b1;
        if (fire) begin
          load       = 1'b1;
          next_state = START;
        end
      end
      START: begin
        line = 1'b0;
        if (tick) begin
          idx_clr    = 1'b1;
          next_state = DATA;
        end
      end
      DATA: begin
        line = shift_q[0];
        if (tick) begin
          if (bit_idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end else begin
            idx_inc  = 1'b1;
            shift_en = 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        line = parity_q;
        if (tick) begin
          next_state = STOP;
        end
`else
        next_state = IDLE;
`endif
      end
      STOP: begin
        line = UART_IDLE_LEVEL;
        if (tick) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Shift register: loaded on transfer, shifted right at each data bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else if (load) begin
      shift_q <= in_data;
    end else if (shift_en) begin
      shift_q <= {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  // Data bit index: restarts on entry to DATA, holds its value elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx_q <= '0;
    end else if (idx_clr) begin
      bit_idx_q <= '0;
    end else if (idx_inc) begin
      bit_idx_q <= bit_idx_q + 1'b1;
    end
  end

  // Ready is withheld until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the byte, captured at transfer since the shifter is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^in_data;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed bench for uart_tx_stream at N = 10 clocks per bit.
// Optional feature macro: UART_TX_PARITY_EN (adds the parity test).
module tb_uart_tx_stream;

  localparam int N = 10;
  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_CYC = (W + 3) * N;
`else
  localparam int FRAME_CYC = (W + 2) * N;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready;
  logic         serial_out;
  logic         busy;

  int n_tests = 0;
  int n_fail = 0;
  logic [0:0] exp_q[$];
  logic par_seen = 1'b0;

  uart_tx_stream #(
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100),
    .WIDTH      (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .serial_out (serial_out),
    .busy       (busy)
  );

  // Clock and reset block.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected line levels of one frame, one entry per clock cycle.
  task automatic push_frame(input logic [W-1:0] b);
    repeat (N) exp_q.push_back(1'b0);
    for (int i = 0; i < W; i++) begin
      repeat (N) exp_q.push_back(b[i]);
    end
`ifdef UART_TX_PARITY_EN
    repeat (N) exp_q.push_back(^b);
`endif
    repeat (N) exp_q.push_back(1'b1);
  endtask

  // Call right after the transfer edge; checks every cycle of the frame.
  task automatic check_frame(input logic [W-1:0] b, input string tag);
    push_frame(b);
    for (int i = 0; i < FRAME_CYC; i++) begin
      @(negedge clk);
      check({tag, "_line"}, serial_out, exp_q.pop_front());
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_rdy"}, in_ready, 1'b0);
      if (i == (W + 1) * N + N / 2) par_seen = serial_out;
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_line"}, serial_out, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_rdy"}, in_ready, 1'b1);
  endtask

  // Driver: offer one byte, then change in_data to 'after' once accepted.
  task automatic fire(input logic [W-1:0] b, input logic [W-1:0] after);
    @(negedge clk);
    check("rdy_pre_fire", in_ready, 1'b1);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = after;
  endtask

  initial begin
    // Reset held for 5 cycles.
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_line", serial_out, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_rdy", in_ready, 1'b0);
    end
    rst_n = 1'b1;
    #1;
    check("rdy_before_edge", in_ready, 1'b0);
    @(posedge clk);
    #1;
    check("rdy_after_edge", in_ready, 1'b1);

    // Single frame 8'hA5, then a quiet idle line.
    fire(8'hA5, 8'h00);
    check_frame(8'hA5, "a5");
    check_idle("a5");
    repeat (20) begin
      @(negedge clk);
      check("quiet_line", serial_out, 1'b1);
      check("quiet_busy", busy, 1'b0);
    end

    // Back-to-back frames with in_valid held high.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h00;
    @(posedge clk);
    #1;
    in_data = 8'hFF;
    check_frame(8'h00, "b2b0");
    check_idle("b2b_gap");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_frame(8'hFF, "b2b1");
    check_idle("b2b1");

    // in_data changes after transfer have no effect.
    fire(8'hC3, 8'h3C);
    check_frame(8'hC3, "c3");
    check_idle("c3");

    // Reset during cycle 45 of a frame (data bit 3 of 8'h55 is 0).
    fire(8'h55, 8'h00);
    push_frame(8'h55);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      check("pre_rst_line", serial_out, exp_q.pop_front());
    end
    check("pre_rst_low", serial_out, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_line", serial_out, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rdy", in_ready, 1'b0);
    exp_q.delete();
    repeat (3) begin
      @(negedge clk);
      check("midrst_hold_line", serial_out, 1'b1);
      check("midrst_hold_busy", busy, 1'b0);
    end
    rst_n = 1'b1;
    fire(8'h96, 8'h00);
    check_frame(8'h96, "post_rst");
    check_idle("post_rst");

`ifdef UART_TX_PARITY_EN
    fire(8'h07, 8'h00);
    check_frame(8'h07, "p07");
    check("par07", par_seen, 1'b1);
    check_idle("p07");
    fire(8'h03, 8'h00);
    check_frame(8'h03, "p03");
    check("par03", par_seen, 1'b0);
    check_idle("p03");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
